act_unit: RTL

Parametrised, pipelined FP32 activation unit: the multi-lane, multi-mode successor to the single-lane `relu`. It applies ReLU, leaky ReLU, ReLU6 or passthrough to `LANES` IEEE-754 single-precision values per beat behind a valid/ready handshake. It also keeps a saturating count of lanes that were zeroed or clamped. It sits between the MAC/accumulator output and the layer writeback path.

---
 rtl/act_pkg.sv | 26 ++
 rtl/act_lane.sv | 59 +++++
 rtl/act_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the FP32 activation unit.
//   act_mode_e  - per-beat activation mode encoding
//   FP_SIX      - 6.0f, the ReLU6 clamp value
//   FP_NEG_ZERO - -0.0f, the leaky flush value
//   lane_cls_t  - per-lane classification captured in the first stage
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_RELU6 = 2'd2,
    ACT_PASS  = 2'd3
  } act_mode_e;

  localparam logic [31:0] FP_SIX      = 32'h40C0_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  typedef struct packed {
    logic nan;      // exponent all ones, mantissa non-zero
    logic sgn;      // sign bit
    logic e_max;    // exponent all ones (inf or NaN)
    logic e_small;  // exponent <= SHIFT, leaky result would go denormal
    logic gt_six;   // magnitude bits above 6.0 (covers +inf)
  } lane_cls_t;

endpackage

// File: rtl/act_lane.sv
// act_lane: one FP32 lane, purely combinational.
//   raw/cls           - classify path, feeds the first pipeline register
//   data/cls_q/mode   - compute path, operates on the registered beat
//   res/hit           - lane result and "zeroed or clamped" flag
module act_lane
  import act_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic [31:0] raw,
  output lane_cls_t   cls,
  input  logic [31:0] data,
  input  lane_cls_t   cls_q,
  input  act_mode_e   mode,
  output logic [31:0] res,
  output logic        hit
);

  localparam logic [7:0] SH = 8'(SHIFT);

  always_comb begin
    cls.e_max   = &raw[30:23];
    cls.nan     = (&raw[30:23]) && (|raw[22:0]);
    cls.sgn     = raw[31];
    cls.e_small = raw[30:23] <= SH;
    cls.gt_six  = raw[30:0] > FP_SIX[30:0];
  end

  always_comb begin
    res = data;
    hit = 1'b0;
    if (!cls_q.nan) begin
      unique case (mode)
        ACT_RELU: if (cls_q.sgn) begin
          res = '0;
          hit = 1'b1;
        end
        ACT_LEAKY: if (cls_q.sgn && !cls_q.e_max) begin
          // exponent-only scaling; results that would be denormal flush to -0
          if (cls_q.e_small) begin
            res = FP_NEG_ZERO;
            hit = 1'b1;
          end else begin
            res = {1'b1, data[30:23] - SH, data[22:0]};
          end
        end
        ACT_RELU6: if (cls_q.sgn) begin
          res = '0;
          hit = 1'b1;
        end else if (cls_q.gt_six) begin
          res = FP_SIX;
          hit = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/act_unit.sv
// act_unit: pipelined multi-lane FP32 activation (ReLU/leaky/ReLU6/pass).
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - input handshake; in_data = LANES x FP32, in_mode per beat
//   out_valid/out_ready  - output handshake; out_data held while stalled
//   clr_cnt              - synchronous clear of sat_cnt (beats an increment)
//   sat_cnt              - saturating count of zeroed/clamped lanes
// Stage 1 holds data, mode and classification; stage 2 holds result and count.
module act_unit
  import act_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SHIFT = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sat_cnt
);

  localparam int STAGES = 2;
  localparam int CW     = $clog2(LANES + 1);

  // vld_pipe[0] is the incoming beat, [1] stage 1, [2] stage 2
  logic [STAGES:0]             vld_pipe;
  logic                        adv;

  logic [LANES-1:0][31:0]      lane_in;
  lane_cls_t [LANES-1:0]       cls_d;
  logic [LANES-1:0][31:0]      s1_data;
  lane_cls_t [LANES-1:0]       s1_cls;
  act_mode_e                   s1_mode;

  logic [LANES-1:0][31:0]      res;
  logic [LANES-1:0]            hit;
  logic [CW-1:0]               hit_cnt;

  logic [LANES-1:0][31:0]      s2_data;
  logic [CW-1:0]               s2_cnt;
  logic [CNT_W:0]              sat_sum;

  assign lane_in     = in_data;
  assign vld_pipe[0] = in_valid;
  assign adv         = !vld_pipe[2] || out_ready;
  assign in_ready    = !vld_pipe[1] || adv;
  assign out_valid   = vld_pipe[2];
  assign out_data    = s2_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(.SHIFT(SHIFT)) u_lane (
      .raw   (lane_in[g]),
      .cls   (cls_d[g]),
      .data  (s1_data[g]),
      .cls_q (s1_cls[g]),
      .mode  (s1_mode),
      .res   (res[g]),
      .hit   (hit[g])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + CW'(hit[i]);
  end

  // stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_data     <= '0;
      s1_cls      <= '0;
      s1_mode     <= ACT_RELU;
    end else if (in_ready) begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        s1_data <= lane_in;
        s1_cls  <= cls_d;
        s1_mode <= act_mode_e'(in_mode);
      end
    end
  end

  // stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      s2_data     <= '0;
      s2_cnt      <= '0;
    end else if (adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        s2_data <= res;
        s2_cnt  <= hit_cnt;
      end
    end
  end

  // one extra bit catches overflow for saturation
  assign sat_sum = {1'b0, sat_cnt} + (CNT_W + 1)'(s2_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sat_cnt <= '0;
    else if (clr_cnt)                sat_cnt <= '0;
    else if (out_valid && out_ready) sat_cnt <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
  end

endmodule
